keypad3x3_scan: RTL

Scans a 3x3 matrix keypad, synchronizes and debounces the row returns, and emits the pressed key as an 8-bit event code 1..9. The code is held for a fixed pulse shorter than 1 s and then returns to 0. The block is the event source feeding the 8-bit event-code input of the buzzer alarm block, on the 50 MHz system clock.

---
 rtl/keypad3x3_scan.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/keypad3x3_scan.sv
// keypad3x3_scan: 3x3 matrix keypad scanner with row sync, debounce
// and a fixed-length key-code pulse feeding the alarm event input.
module keypad3x3_scan #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int SCAN_DIV  = 50_000,
  parameter int DEB_CNT   = 20,
  parameter int PULSE_CYC = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] row_n,
  output logic [2:0] col_n,
  output logic [7:0] key_code,
  output logic       key_valid
);

  // pulse length is kept strictly below one second of clock
  localparam int PLEN = (PULSE_CYC < CLK_HZ) ? PULSE_CYC : CLK_HZ - 1;
  localparam int SW   = $clog2(SCAN_DIV);
  localparam int DW   = $clog2(DEB_CNT + 1);
  localparam int PW   = $clog2(PLEN + 1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_e;

  logic [2:0]    meta_q, row_s_q;
  logic [SW-1:0] slot_q, slot_d;
  logic [1:0]    col_q, col_d;
  state_e        state_q, state_d;
  logic [1:0]    cand_q, cand_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [DW-1:0] rel_q, rel_d;
  logic [PW-1:0] pulse_q, pulse_d;
  logic [7:0]    code_q, code_d;
  logic          valid_q, valid_d;

  logic          sample;
  logic          hit;
  logic          confirm;
  logic [1:0]    row_idx;
  logic [1:0]    col_nx;
  logic [7:0]    new_code;

  always_comb begin
    sample   = (slot_q == SW'(SCAN_DIV - 1));
    hit      = ~&row_s_q;
    row_idx  = !row_s_q[0] ? 2'd0 :
               !row_s_q[1] ? 2'd1 : 2'd2;
    col_nx   = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
    new_code = 8'(row_idx) * 8'd3 + 8'(col_q) + 8'd1;
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cand_d  = cand_q;
    deb_d   = deb_q;
    rel_d   = rel_q;
    confirm = 1'b0;
    slot_d  = sample ? '0 : slot_q + 1'b1;
    if (sample) begin
      unique case (state_q)
        SCAN: begin
          if (hit) begin
            cand_d = row_idx;
            if (DEB_CNT == 1) begin
              confirm = 1'b1;
              deb_d   = '0;
              rel_d   = '0;
              state_d = HELD;
            end else begin
              deb_d   = DW'(1);
              state_d = DEBOUNCE;
            end
          end else begin
            col_d = col_nx;
          end
        end
        DEBOUNCE: begin
          if (hit && row_idx == cand_q) begin
            if (deb_q + 1'b1 == DW'(DEB_CNT)) begin
              confirm = 1'b1;
              deb_d   = '0;
              rel_d   = '0;
              state_d = HELD;
            end else begin
              deb_d = deb_q + 1'b1;
            end
          end else begin
            deb_d   = '0;
            col_d   = col_nx;
            state_d = SCAN;
          end
        end
        HELD: begin
          if (hit) begin
            rel_d = '0;
          end else if (rel_q + 1'b1 == DW'(DEB_CNT)) begin
            rel_d   = '0;
            col_d   = col_nx;
            state_d = SCAN;
          end else begin
            rel_d = rel_q + 1'b1;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  // a new confirmation always restarts the pulse, even mid-pulse
  always_comb begin
    valid_d = confirm;
    code_d  = code_q;
    pulse_d = pulse_q;
    if (confirm) begin
      code_d  = new_code;
      pulse_d = PW'(PLEN);
    end else if (pulse_q != '0) begin
      pulse_d = pulse_q - 1'b1;
      if (pulse_q == PW'(1)) code_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 3'b111;
      row_s_q <= 3'b111;
      slot_q  <= '0;
      col_q   <= 2'd0;
      state_q <= SCAN;
      cand_q  <= 2'd0;
      deb_q   <= '0;
      rel_q   <= '0;
      pulse_q <= '0;
      code_q  <= 8'd0;
      valid_q <= 1'b0;
    end else begin
      meta_q  <= row_n;
      row_s_q <= meta_q;
      slot_q  <= slot_d;
      col_q   <= col_d;
      state_q <= state_d;
      cand_q  <= cand_d;
      deb_q   <= deb_d;
      rel_q   <= rel_d;
      pulse_q <= pulse_d;
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

  assign col_n     = ~(3'b001 << col_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;

endmodule
